fw_out_collector: RTL and testbench
===================================

# fw_out_collector

Downstream stage of the Floyd-Warshall compute kernel: captures each `L*WIDTH`-bit result beat the kernel emits, buffers it in a small FIFO, and writes it back to tile memory through a valid/ready write port at consecutive addresses. Because the kernel has no output backpressure, the block drives `inhibit` early enough to cover the kernel's 8-cycle pipeline. It signals tile completion with a one-cycle `done` pulse.

## Interface
- `L`, default `` `L `` (params.v), number of lanes per beat
- `WIDTH`, default `` `WIDTH `` (params.v), bits per lane
- `DEPTH`, default 16, FIFO entries (power of two, ≥ 2*`AFULL_MARGIN`)
- `AFULL_MARGIN`, default 8, free slots reserved for kernel in-flight beats
- `AW`, default 16, write-address width
- `clk`  in  1  clock, all logic on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle pulse; latches `base_addr`, `num_rows`
- `base_addr`  in  AW  first write address of the tile
- `num_rows`  in  16  beats expected for this tile
- `inD`  in  L*WIDTH  result beat from kernel `outD`
- `in_valid`  in  1  kernel `out_valid`
- `inhibit`  out  1  stall request to kernel/feeder
- `wr_addr`  out  AW  memory write address
- `wr_data`  out  L*WIDTH  memory write data
- `wr_valid`  out  1  write request
- `wr_ready`  in  1  memory accepts write
- `busy`  out  1  high in RUN
- `done`  out  1  one-cycle tile-complete pulse
- `overflow`  out  1  sticky error flag
- `checksum`  out  WIDTH  tile checksum (only with FW_COLLECT_CSUM_EN)

## Operation
- FSM: IDLE, RUN.
- IDLE -> RUN on `start`: latch `base_addr` and `num_rows`; clear the received count, written count, `overflow` and checksum.
- `start` with `num_rows`=0: stay in IDLE; `done` is high the next cycle.
- `start` during RUN is ignored.
- Push: `in_valid` in RUN and received count < `num_rows`.
  - Accepted if count < `DEPTH`, or if a pop occurs in the same cycle.
  - Otherwise the beat is dropped and `overflow` is set.
- `in_valid` in RUN once `num_rows` beats have been received: the beat is dropped and `overflow` is set.
- `in_valid` in IDLE: ignored, no flag.
- Pop: `wr_valid && wr_ready`.
  - `wr_addr` = latched base + written count, wrapping modulo 2^AW.
  - The written count increments.
- `wr_valid` = FIFO not empty. `wr_data` and `wr_addr` stay stable while `wr_valid && !wr_ready`.
- RUN -> IDLE on the pop that makes the written count equal `num_rows`. `done` is high the following cycle.
- `inhibit` = (count ≥ `DEPTH`-`AFULL_MARGIN`), registered. It is low in IDLE.
- `busy` = state is RUN.

## Timing
- Reset values:
  - state = IDLE
  - FIFO empty
  - `wr_valid`=0, `wr_addr`=0, `wr_data`=0
  - `inhibit`=0, `busy`=0, `done`=0, `overflow`=0, `checksum`=0
- Latency: beat accepted at edge k into an empty FIFO gives `wr_valid`=1 after edge k+1.
- Throughput: one beat per cycle when `wr_ready` is held high.
- `inhibit` asserts one cycle after the count crosses the threshold. Up to 8 more kernel beats can still arrive; `AFULL_MARGIN` ≥ 8 guarantees they fit.
- `done` is exactly one cycle wide, after the final write handshake.
- Assertion of `reset` mid-tile clears everything immediately. In-flight beats are lost and no `done` is produced.

## Configuration
- `FW_COLLECT_CSUM_EN` defined:
  - `checksum` = XOR of all `WIDTH` lanes of every written beat in the tile.
  - Updated on each pop; cleared on `start`; valid when `done` is high.
- Undefined: `checksum` port absent, no checksum logic.

## Structure
- Shared package/header:
  - `L`, `WIDTH` (params.v)
  - FSM state encoding (IDLE=1'b0, RUN=1'b1)
  - default `DEPTH`/`AFULL_MARGIN`
  - kernel pipeline latency constant (8)
- One sub-module: `fw_sync_fifo`, a parameterised width/depth synchronous FIFO with count, async active-low reset and same-cycle push/pop. The FSM, address counter and checksum live in `fw_out_collector`.

## Test plan
- `num_rows`=4, `base_addr`=0x100, 4 consecutive `in_valid` beats, `wr_ready`=1 -> writes to 0x100..0x103 in order, first `wr_valid` one cycle after first beat, `done` pulse one cycle after 4th write.
- `wr_ready`=0 while 8 beats arrive (`DEPTH`=16) -> `inhibit` high after the count reaches 8. Hold `wr_ready`=0 through 8 further beats: no `overflow`, 16 entries stored. Release -> 16 ordered writes.
- FIFO full (16), 17th beat with `wr_ready`=0 -> beat dropped, `overflow`=1 and held until next `start`. Same case with `wr_ready`=1 -> beat accepted, no overflow.
- `base_addr`=0xFFFE, `num_rows`=3 -> addresses 0xFFFE, 0xFFFF, 0x0000.
- `num_rows`=0 -> `done` the cycle after `start`, no writes. `reset` asserted after 2 of 4 writes -> all outputs 0 immediately, no `done`.
- With `FW_COLLECT_CSUM_EN`, L=2, beats {0x0F,0xF0} and {0x01,0x00} -> `checksum`=0xFE when `done` is high.

Source files
------------

// File: rtl/fw_out_collector_pkg.sv
// Shared constants and FSM encoding for the Floyd-Warshall output collector.
// L/WIDTH mirror the kernel's params.v values.
package fw_out_collector_pkg;

  localparam int unsigned FW_L              = 2;
  localparam int unsigned FW_WIDTH          = 8;
  localparam int unsigned FW_KERNEL_LATENCY = 8;
  localparam int unsigned FW_DEPTH          = 16;
  // Every beat already in the kernel pipeline must still fit after inhibit rises.
  localparam int unsigned FW_AFULL_MARGIN   = FW_KERNEL_LATENCY;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/fw_sync_fifo.sv
// Parameterised synchronous FIFO with occupancy count and same-cycle push/pop.
// Read data is the combinational head entry; the consumer registers it.
module fw_sync_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata_c,
  output logic                     empty_c,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          full;
  logic          push_ok;
  logic          pop_ok;

  assign empty_c = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_ok  = pop && !empty_c;
  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop_ok);
  assign rdata_c = mem[rptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + PW'(1);
      if (pop_ok)  rptr <= rptr + PW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/fw_out_collector.sv
// Collects kernel result beats into a FIFO and writes them to tile memory at
// consecutive addresses. Optional tile checksum under FW_COLLECT_CSUM_EN.
module fw_out_collector
  import fw_out_collector_pkg::*;
#(
  parameter int unsigned L            = FW_L,
  parameter int unsigned WIDTH        = FW_WIDTH,
  parameter int unsigned DEPTH        = FW_DEPTH,
  parameter int unsigned AFULL_MARGIN = FW_AFULL_MARGIN,
  parameter int unsigned AW           = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [AW-1:0]        base_addr,
  input  logic [15:0]          num_rows,
  input  logic [L*WIDTH-1:0]   inD,
  input  logic                 in_valid,
  output logic                 inhibit,
  output logic [AW-1:0]        wr_addr,
  output logic [L*WIDTH-1:0]   wr_data,
  output logic                 wr_valid,
  input  logic                 wr_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow
`ifdef FW_COLLECT_CSUM_EN
  ,
  output logic [WIDTH-1:0]     checksum
`endif
);

  localparam int unsigned DW  = L * WIDTH;
  localparam int unsigned CW  = $clog2(DEPTH) + 1;
  localparam int unsigned THR = DEPTH - AFULL_MARGIN;

  state_e          state;
  logic [15:0]     rows_q;
  logic [15:0]     rcv_cnt;
  logic [15:0]     wr_cnt;
  logic [CW-1:0]   fifo_count;
  logic [CW-1:0]   total_c;
  logic [DW-1:0]   fifo_rdata;
  logic            fifo_empty;
  logic            in_run;
  logic            pop;
  logic            load;
  logic            want;
  logic            accept;
  logic            drop;
  logic            last_pop;

  assign in_run   = (state == RUN);
  assign busy     = in_run;
  assign pop      = wr_valid && wr_ready;
  // Refill the output register whenever it is empty or being consumed.
  assign load     = !fifo_empty && (!wr_valid || wr_ready);
  // Occupancy includes the beat parked in the output register.
  assign total_c  = fifo_count + CW'(wr_valid);
  assign want     = in_run && in_valid && (rcv_cnt < rows_q);
  assign accept   = want && ((total_c < CW'(DEPTH)) || pop);
  assign drop     = in_run && in_valid && !accept;
  assign last_pop = pop && (16'(wr_cnt + 16'd1) == rows_q);

  fw_sync_fifo #(
    .W     (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (accept),
    .wdata   (inD),
    .pop     (load),
    .rdata_c (fifo_rdata),
    .empty_c (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      rows_q   <= '0;
      rcv_cnt  <= '0;
      wr_cnt   <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
      wr_valid <= 1'b0;
      inhibit  <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done    <= 1'b0;
      inhibit <= in_run && (total_c >= CW'(THR));

      if (load) begin
        wr_valid <= 1'b1;
        wr_data  <= fifo_rdata;
      end else if (pop) begin
        wr_valid <= 1'b0;
      end

      if (pop) begin
        wr_addr <= wr_addr + AW'(1);
        wr_cnt  <= wr_cnt + 16'd1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            rows_q   <= num_rows;
            rcv_cnt  <= '0;
            wr_cnt   <= '0;
            overflow <= 1'b0;
            wr_addr  <= base_addr;
            if (num_rows == '0) done  <= 1'b1;
            else                state <= RUN;
          end
        end
        RUN: begin
          if (accept) rcv_cnt  <= rcv_cnt + 16'd1;
          if (drop)   overflow <= 1'b1;
          if (last_pop) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
      endcase
    end
  end

`ifdef FW_COLLECT_CSUM_EN
  logic [WIDTH-1:0] lane_x_c;

  // XOR-fold all lanes of the beat currently being written.
  always_comb begin
    lane_x_c = '0;
    for (int i = 0; i < int'(L); i++) lane_x_c = lane_x_c ^ wr_data[i*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                   checksum <= '0;
    else if (!in_run && start)    checksum <= '0;
    else if (pop)                 checksum <= checksum ^ lane_x_c;
  end
`endif

endmodule

// File: tb/tb_fw_out_collector.sv
// Directed self-checking bench for fw_out_collector (default L=2, WIDTH=8,
// DEPTH=16); checksum scenario only when FW_COLLECT_CSUM_EN is defined.
module tb_fw_out_collector;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] base_addr;
  logic [15:0] num_rows;
  logic [15:0] inD;
  logic        in_valid;
  logic        inhibit;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic        busy;
  logic        done;
  logic        overflow;
`ifdef FW_COLLECT_CSUM_EN
  logic [7:0]  checksum;
`endif

  int n_cmp = 0;
  int n_err = 0;

  fw_out_collector dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .num_rows  (num_rows),
    .inD       (inD),
    .in_valid  (in_valid),
    .inhibit   (inhibit),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow)
`ifdef FW_COLLECT_CSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] beat(input logic [15:0] seed, input int k);
    return seed + 16'(k) * 16'h0101;
  endfunction

  task automatic start_tile(input logic [15:0] b, input logic [15:0] n);
    start     = 1'b1;
    base_addr = b;
    num_rows  = n;
    step;
    start     = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; wr_ready = 1'b0;
    inD = '0; base_addr = '0; num_rows = '0;
    step; step;
    n_cmp++;
    if ({wr_valid, inhibit, busy, done, overflow} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_flags: got %b want 00000", {wr_valid, inhibit, busy, done, overflow});
    end
    n_cmp++;
    if (wr_addr !== 16'h0 || wr_data !== 16'h0) begin
      n_err++;
      $display("FAIL reset_bus: got addr %h data %h want 0000 0000", wr_addr, wr_data);
    end
    reset = 1'b1;
    step;
  endtask

  task automatic test_basic;
    int n_wr = 0;
    int n_done = 0;
    int done_c = -1;
    start_tile(16'h0100, 16'd4);
    n_cmp++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %b want 1", busy); end
    wr_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c == 1) begin
        n_cmp++;
        if (wr_valid !== 1'b0) begin n_err++; $display("FAIL basic_latency_early: got wr_valid %b want 0", wr_valid); end
      end
      if (c == 2) begin
        n_cmp++;
        if (wr_valid !== 1'b1) begin n_err++; $display("FAIL basic_latency: got wr_valid %b want 1", wr_valid); end
      end
      if (wr_valid && wr_ready) begin
        n_cmp++;
        if (wr_addr !== 16'h0100 + 16'(n_wr) || wr_data !== beat(16'h1000, n_wr)) begin
          n_err++;
          $display("FAIL basic_write[%0d]: got addr %h data %h want addr %h data %h",
                   n_wr, wr_addr, wr_data, 16'h0100 + 16'(n_wr), beat(16'h1000, n_wr));
        end
        n_wr++;
      end
      if (done) begin n_done++; done_c = c; end
      in_valid = (c < 4);
      inD      = beat(16'h1000, c);
      step;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (n_wr !== 4) begin n_err++; $display("FAIL basic_count: got %0d writes want 4", n_wr); end
    n_cmp++;
    if (n_done !== 1 || done_c !== 6) begin
      n_err++;
      $display("FAIL basic_done: got %0d pulses at cycle %0d want 1 at cycle 6", n_done, done_c);
    end
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL basic_idle: got busy %b want 0", busy); end
  endtask

  task automatic test_fill_overflow;
    int n_wr = 0;
    int n_done = 0;
    start_tile(16'h0200, 16'd17);
    wr_ready = 1'b0;
    for (int k = 0; k < 16; k++) begin
      in_valid = 1'b1;
      inD      = beat(16'h2000, k);
      step;
      n_cmp++;
      if (inhibit !== 1'(k >= 8)) begin
        n_err++;
        $display("FAIL fill_inhibit[%0d]: got %b want %b", k, inhibit, 1'(k >= 8));
      end
    end
    n_cmp++;
    if (overflow !== 1'b0 || wr_valid !== 1'b1) begin
      n_err++;
      $display("FAIL fill_16: got overflow %b wr_valid %b want 0 1", overflow, wr_valid);
    end
    inD = 16'hDEAD;
    step;
    in_valid = 1'b0;
    n_cmp++;
    if (overflow !== 1'b1) begin n_err++; $display("FAIL fill_drop: got overflow %b want 1", overflow); end
    wr_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (wr_valid && wr_ready) begin
        n_cmp++;
        if (wr_addr !== 16'h0200 + 16'(n_wr) || wr_data !== beat(16'h2000, n_wr)) begin
          n_err++;
          $display("FAIL fill_write[%0d]: got addr %h data %h want addr %h data %h",
                   n_wr, wr_addr, wr_data, 16'h0200 + 16'(n_wr), beat(16'h2000, n_wr));
        end
        n_wr++;
      end
      if (c == 22) begin
        n_cmp++;
        if (overflow !== 1'b1) begin n_err++; $display("FAIL fill_sticky: got overflow %b want 1", overflow); end
      end
      if (done) n_done++;
      in_valid = (c == 20);
      inD      = beat(16'h2000, 16);
      step;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (n_wr !== 17 || n_done !== 1) begin
      n_err++;
      $display("FAIL fill_drain: got %0d writes %0d done want 17 1", n_wr, n_done);
    end
  endtask

  task automatic test_full_with_pop;
    int n_wr = 0;
    int n_done = 0;
    start_tile(16'h0300, 16'd17);
    n_cmp++;
    if (overflow !== 1'b0) begin n_err++; $display("FAIL start_clears_overflow: got %b want 0", overflow); end
    wr_ready = 1'b0;
    for (int k = 0; k < 16; k++) begin
      in_valid = 1'b1;
      inD      = beat(16'h3000, k);
      step;
    end
    wr_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (wr_valid && wr_ready) begin
        n_cmp++;
        if (wr_addr !== 16'h0300 + 16'(n_wr) || wr_data !== beat(16'h3000, n_wr)) begin
          n_err++;
          $display("FAIL fullpop_write[%0d]: got addr %h data %h want addr %h data %h",
                   n_wr, wr_addr, wr_data, 16'h0300 + 16'(n_wr), beat(16'h3000, n_wr));
        end
        n_wr++;
      end
      if (done) n_done++;
      in_valid = (c == 0);
      inD      = beat(16'h3000, 16);
      step;
      if (c == 0) begin
        n_cmp++;
        if (overflow !== 1'b0) begin n_err++; $display("FAIL fullpop_accept: got overflow %b want 0", overflow); end
      end
    end
    in_valid = 1'b0;
    n_cmp++;
    if (n_wr !== 17 || n_done !== 1) begin
      n_err++;
      $display("FAIL fullpop_drain: got %0d writes %0d done want 17 1", n_wr, n_done);
    end
  endtask

  task automatic test_wrap;
    logic [15:0] exp_addr [3];
    int n_wr = 0;
    int n_done = 0;
    exp_addr = '{16'hFFFE, 16'hFFFF, 16'h0000};
    start_tile(16'hFFFE, 16'd3);
    wr_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (wr_valid && wr_ready) begin
        n_cmp++;
        if (n_wr > 2 || wr_addr !== exp_addr[n_wr % 3] || wr_data !== beat(16'h7000, n_wr)) begin
          n_err++;
          $display("FAIL wrap_write[%0d]: got addr %h data %h want addr %h data %h",
                   n_wr, wr_addr, wr_data, exp_addr[n_wr % 3], beat(16'h7000, n_wr));
        end
        n_wr++;
      end
      if (done) n_done++;
      in_valid = (c < 3);
      inD      = beat(16'h7000, c);
      step;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (n_wr !== 3 || n_done !== 1) begin
      n_err++;
      $display("FAIL wrap_count: got %0d writes %0d done want 3 1", n_wr, n_done);
    end
  endtask

  task automatic test_zero_rows;
    start_tile(16'h0500, 16'd0);
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL zero_done: got done %b busy %b want 1 0", done, busy);
    end
    step;
    n_cmp++;
    if (done !== 1'b0 || wr_valid !== 1'b0) begin
      n_err++;
      $display("FAIL zero_after: got done %b wr_valid %b want 0 0", done, wr_valid);
    end
  endtask

  task automatic test_reset_mid;
    int n_wr = 0;
    int n_bad = 0;
    start_tile(16'h0400, 16'd4);
    wr_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (wr_valid && wr_ready) n_wr++;
      in_valid = (c < 4);
      inD      = beat(16'h4000, c);
      step;
      if (n_wr == 2) break;
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    n_cmp++;
    if ({wr_valid, inhibit, busy, done, overflow} !== 5'b0 || wr_addr !== 16'h0 || wr_data !== 16'h0) begin
      n_err++;
      $display("FAIL midreset_clear: got flags %b addr %h data %h want 00000 0000 0000",
               {wr_valid, inhibit, busy, done, overflow}, wr_addr, wr_data);
    end
    step; step;
    reset = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step;
      if (done || wr_valid) n_bad++;
    end
    n_cmp++;
    if (n_bad !== 0) begin n_err++; $display("FAIL midreset_quiet: got %0d active cycles want 0", n_bad); end
  endtask

`ifdef FW_COLLECT_CSUM_EN
  task automatic test_checksum;
    int n_done = 0;
    start_tile(16'h0600, 16'd2);
    wr_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (done) begin
        n_done++;
        n_cmp++;
        if (checksum !== 8'hFE) begin n_err++; $display("FAIL csum_value: got %h want fe", checksum); end
      end
      in_valid = (c < 2);
      inD      = (c == 0) ? 16'h0FF0 : 16'h0100;
      step;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (n_done !== 1) begin n_err++; $display("FAIL csum_done: got %0d done want 1", n_done); end
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_basic;
    test_fill_overflow;
    test_full_with_pop;
    test_wrap;
    test_zero_rows;
`ifdef FW_COLLECT_CSUM_EN
    test_checksum;
`endif
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
